rs232_tx_arbiter: RTL

Shares the single RS232 transmitter among NCORES requesting cores, so that console output from different cores never interleaves within a line. A core keeps its grant until it sends a newline (0x0A) or stops sending for HOLD_TIMEOUT cycles. Grants are then passed on in round-robin order. The block sits between the per-core console write paths and the UART's write interface (tx_write/tx_data), and paces bytes by the UART's txReady.

---
 rtl/rs232_pkg.sv | 21 ++
 rtl/rr_pick.sv | 27 ++
 rtl/rs232_tx_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared types for the RS232 console arbiters: FSM encoding, no-owner marker, default EOL byte.
// Pure declarations; no latency or flow control of its own.
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_SEND   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

    localparam logic [3:0] NO_OWNER    = 4'hF;
    localparam logic [7:0] EOL_DEFAULT = 8'h0A;

    // Successor of idx in a ring of n entries.
    function automatic logic [3:0] rr_next(input logic [3:0] idx, input int n);
        return (int'(idx) >= n - 1) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request at or after ptr_i, searching upward with wrap.
// Purely combinational; ptr_i must be below N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Outer loop walks priority distance from ptr_i; inner loop maps it to a request line.
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found_o && req_i[j] && (j == (int'(ptr_i) + k) % N)) begin
                    found_o = 1'b1;
                    idx_o   = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Grants the single UART transmitter to one core at a time until EOL or idle timeout, round-robin.
// tx_write 2 cycles after a request from IDLE; bytes paced by tx_ready, one ack per accepted byte.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int         NCORES       = 4,
    parameter int         HOLD_TIMEOUT = 100000,
    parameter logic [7:0] EOL_CHAR     = EOL_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCORES-1:0]     req,
    input  logic [8*NCORES-1:0]   data,
    output logic [NCORES-1:0]     ack,
    input  logic                  tx_ready,
    output logic                  tx_write,
    output logic [7:0]            tx_data,
    output logic [3:0]            owner,
    output logic                  busy
);

    localparam int             CW       = $clog2(HOLD_TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    state_e          state_q, state_d;
    logic [3:0]      owner_q, owner_d;
    logic [3:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [7:0]      last_byte_q, last_byte_d;

    logic              own_req;
    logic [7:0]        own_data;
    logic [NCORES-1:0] own_onehot;
    logic              pick_found;
    logic [3:0]        pick_idx;

    rr_pick #(.N(NCORES), .IW(4)) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Select the current owner's request and byte; everything is zero when nobody owns the grant.
    always_comb begin
        own_req    = 1'b0;
        own_data   = 8'h00;
        own_onehot = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (owner_q == 4'(i)) begin
                own_req       = req[i];
                own_data      = data[8*i +: 8];
                own_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        idle_cnt_d  = '0;
        last_byte_d = last_byte_q;
        ack         = '0;
        tx_write    = 1'b0;
        tx_data     = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (own_req) begin
                    if (tx_ready) state_d = ST_SEND;
                end else if (idle_cnt_q == CNT_LAST) begin
                    owner_d  = NO_OWNER;
                    rr_ptr_d = rr_next(owner_q, NCORES);
                    state_d  = ST_IDLE;
                end else if (idle_cnt_q != CNT_MAX) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
            end
            ST_SEND: begin
                tx_write    = 1'b1;
                tx_data     = own_data;
                ack         = own_onehot;
                last_byte_d = own_data;
                state_d     = ST_SETTLE;
            end
            // The UART's empty flag only drops one cycle after the write, so tx_ready is not trusted here.
            ST_SETTLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_ready) begin
                    if (last_byte_q == EOL_CHAR) begin
                        owner_d  = NO_OWNER;
                        rr_ptr_d = rr_next(owner_q, NCORES);
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            default: begin
                owner_d = NO_OWNER;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= NO_OWNER;
            rr_ptr_q    <= 4'd0;
            idle_cnt_q  <= '0;
            last_byte_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            idle_cnt_q  <= idle_cnt_d;
            last_byte_q <= last_byte_d;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
